dmem_cache: RTL and testbench
=============================

DMEM_CACHE -- requirements
Module: dmem_cache

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width; legal value is 32 only.
REQ-003 The block SHALL have parameter INDEX_BITS, default 6, meaning log2 of the line count; one word per line.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rstn  in  1  reset, synchronous and active-low.
REQ-006 addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
REQ-007 data_in  in  DATA_WIDTH  write data.
REQ-008 write_enable  in  1  write request.
REQ-009 read_enable  in  1  read request.
REQ-010 flush  in  1  one-cycle pulse requesting invalidation of all lines.
REQ-011 data_out  out  DATA_WIDTH  read data, valid when a read request is present and miss=0.
REQ-012 miss  out  1  stall; the requester holds addr/data_in/enables stable while it is 1.
REQ-013 flush_busy  out  1  high while an invalidation sweep is pending or running.
REQ-014 mem_addr  out  ADDR_WIDTH  backing-memory word address, bits [1:0] zero.
REQ-015 mem_wdata  out  DATA_WIDTH  backing-memory write data.
REQ-016 mem_re / mem_we  out  1 each  backing-memory read and write strobes.
REQ-017 mem_rdata  in  DATA_WIDTH  backing-memory read data, valid with mem_ready.
REQ-018 mem_ready  in  1  backing-memory completion, sampled in FILL and WRITE only.

Function
REQ-019 Organisation SHALL be direct-mapped, write-through, no write-allocate: index = addr[INDEX_BITS+1:2], tag = addr[ADDR_WIDTH-1:INDEX_BITS+2].
REQ-020 The FSM SHALL have states IDLE, FILL, WRITE, DONE, FLUSH.
REQ-021 A read hit in IDLE (valid and tag equal) SHALL give miss=0 and data_out=line data combinationally in the same cycle.
REQ-022 A read miss in IDLE SHALL drive miss=1 combinationally, latch addr, and go to FILL.
REQ-023 A write in IDLE SHALL drive miss=1, latch addr and data_in, and go to WRITE; a write occurs whether or not the line hits.
REQ-024 When read_enable and write_enable are both 1, the request SHALL be treated as a write.
REQ-025 In FILL, mem_re=1 and mem_addr=latched address SHALL be held until mem_ready=1; then tag/data are written, valid is set, and the state goes to DONE.
REQ-026 In WRITE, mem_we=1 with latched address and data SHALL be held until mem_ready=1; then, if the line hits, its data is updated, and the state goes to DONE.
REQ-027 In DONE, miss SHALL be 0 and data_out SHALL be the latched fill/write data; the state returns to IDLE next cycle.
REQ-028 mem_ready=1 in the first FILL/WRITE cycle SHALL give the minimum miss latency: 2 stall cycles.
REQ-029 miss SHALL be 1 in FILL, WRITE and FLUSH whenever either enable is 1, and SHALL be 0 whenever no enable is 1.
REQ-030 A flush pulse SHALL be recorded in a pending flag in any state; flush_busy rises the next cycle.
REQ-031 FLUSH SHALL be entered from IDLE when the pending flag is set, with priority over a new request.
REQ-032 FLUSH SHALL clear one valid bit per cycle with an INDEX_BITS counter from 0 to 2^INDEX_BITS-1, then return to IDLE, clearing flush_busy and the pending flag.
REQ-033 A flush pulse arriving during FLUSH SHALL restart the sweep at index 0.
REQ-034 mem_re and mem_we SHALL never both be 1, and SHALL be 0 outside FILL and WRITE.

Reset
REQ-035 When rstn=0, the state SHALL become IDLE and all valid bits, the flush flag and the sweep counter SHALL be cleared in one cycle.
REQ-036 During reset, the outputs SHALL be: miss=0, flush_busy=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, data_out=0.
REQ-037 Reset during FILL or WRITE SHALL abandon the memory transaction with no line update; tag and data arrays are not reset.

Structure
REQ-038 The state encoding and the index/tag width helper constants SHALL reside in a shared package, dmem_cache_pkg.
REQ-039 The tag/data/valid storage SHALL be one sub-module, dmem_cache_array, with one combinational read port, one synchronous write port, and a valid-clear port.

Verification
REQ-040 The bench SHALL cover this cold read: reset, then read 0x100 with mem_ready after 3 cycles and mem_rdata=0xDEADBEEF -> miss high for 4 cycles, then data_out=0xDEADBEEF; a re-read of 0x100 gives miss=0 the same cycle.
REQ-041 The bench SHALL cover this conflict: read 0x100, then read 0x100+(4<<INDEX_BITS) -> second read misses, and a subsequent read of 0x100 misses again.
REQ-042 The bench SHALL cover this write hit: after filling 0x100, write 0x12345678 to it -> mem_we for exactly one mem_ready handshake, then a read of 0x100 hits with 0x12345678.
REQ-043 The bench SHALL cover this write miss: write 0x200, then read 0x200 -> the read misses (no allocate).
REQ-044 The bench SHALL cover this flush: flush pulse with a read of 0x100 pending -> flush_busy for 2^INDEX_BITS+1 cycles, then the read misses and refills.
REQ-045 The bench SHALL cover this reset case: rstn low during FILL -> mem_re=0 next cycle, and a read of the same address afterwards misses.

Source files
------------

// File: rtl/dmem_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// the controller state encoding and the address-split helpers.
package dmem_cache_pkg;

  // Controller states; the numeric values are visible on state_dbg.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // Byte-offset bits below the index (one 32-bit word per line).
  localparam int OFFSET_BITS = 2;

  // Tag width left over once the index and byte offset are removed.
  function automatic int tag_bits(input int addr_width, input int index_bits);
    return addr_width - index_bits - OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dmem_cache_array.sv
// Tag/data/valid storage for the cache: one combinational read port,
// one synchronous write port (which also sets valid) and a valid-clear port.
// Only the valid bits are reset; tag and data contents are left as they are.
module dmem_cache_array
  import dmem_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr_en,
  input  logic [INDEX_BITS-1:0] clr_index
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      valid_d;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  // Next valid vector: a sweep clear and a line write never target the same cycle.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_index] = 1'b0;
    if (wr_en)  valid_d[wr_index]  = 1'b1;
  end

  // Valid bits are the only reset storage, so reset invalidates every line at once.
  always_ff @(posedge clk) begin
    if (!rstn) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data contents: written on fill or write hit, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
//
// Handshakes: the requester raises read_enable or write_enable and holds addr,
// data_in and the enables stable for as long as miss=1; the access completes in
// the first cycle with an enable high and miss=0 (read data on data_out then).
// Toward memory, mem_re or mem_we is held with a stable mem_addr/mem_wdata
// until mem_ready=1 is seen on a rising edge; that edge ends the transaction.
module dmem_cache
  import dmem_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  miss,
  output logic                  flush_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [2:0]            state_dbg
);

  localparam int TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pend_q, pend_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [INDEX_BITS-1:0] look_index;
  logic [TAG_BITS-1:0]   look_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  arr_wr_en;
  logic [DATA_WIDTH-1:0] arr_wr_data;
  logic                  arr_clr_en;
  logic                  any_en;
  logic                  miss_c;
  logic [DATA_WIDTH-1:0] data_out_c;
  logic                  unused_addr_bits;

  assign any_en           = read_enable | write_enable;
  assign unused_addr_bits = ^{addr[1:0], addr_q[1:0]};

  dmem_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .rstn      (rstn),
    .rd_index  (look_index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (arr_wr_en & rstn),
    .wr_index  (addr_q[INDEX_BITS+1:2]),
    .wr_tag    (addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
    .wr_data   (arr_wr_data),
    .clr_en    (arr_clr_en & rstn),
    .clr_index (cnt_q)
  );

  // Lookup uses the live address in IDLE and the latched one while a miss is in flight.
  always_comb begin
    if (state_q == ST_IDLE) begin
      look_index = addr[INDEX_BITS+1:2];
      look_tag   = addr[ADDR_WIDTH-1:INDEX_BITS+2];
    end else begin
      look_index = addr_q[INDEX_BITS+1:2];
      look_tag   = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    end
    hit = rd_valid && (rd_tag == look_tag);
  end

  // Next-state, latch and array-update logic; memory strobes follow the next state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_d      = pend_q | flush;
    cnt_d       = cnt_q;
    arr_wr_en   = 1'b0;
    arr_wr_data = mem_rdata;
    arr_clr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pending flush wins over any new request.
        if (pend_q) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (write_enable) begin
          state_d = ST_WRITE;
          addr_d  = addr;
          data_d  = data_in;
        end else if (read_enable && !hit) begin
          state_d = ST_FILL;
          addr_d  = addr;
        end
      end
      ST_FILL: begin
        if (mem_ready) begin
          arr_wr_en   = 1'b1;
          arr_wr_data = mem_rdata;
          data_d      = mem_rdata;
          state_d     = ST_DONE;
        end
      end
      ST_WRITE: begin
        // Write-through without allocate: only a line already holding this tag is updated.
        if (mem_ready) begin
          arr_wr_en   = hit;
          arr_wr_data = data_q;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        arr_clr_en = 1'b1;
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == {INDEX_BITS{1'b1}}) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mem_re_d    = (state_d == ST_FILL);
    mem_we_d    = (state_d == ST_WRITE);
    mem_addr_d  = (mem_re_d || mem_we_d) ? {addr_d[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_wdata_d = mem_we_d ? data_d : '0;
  end

  // Controller register: state, latched request, flush bookkeeping and registered strobes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Stall and read data toward the requester; everything is forced quiet under reset.
  always_comb begin
    miss_c     = 1'b0;
    data_out_c = '0;
    case (state_q)
      ST_IDLE: begin
        miss_c = any_en & (pend_q | write_enable | !hit);
        if (hit) data_out_c = rd_data;
      end
      ST_FILL, ST_WRITE, ST_FLUSH: miss_c = any_en;
      ST_DONE: data_out_c = data_q;
      default: miss_c = 1'b0;
    endcase
  end

  assign miss       = rstn & miss_c;
  assign data_out   = rstn ? data_out_c : '0;
  assign flush_busy = rstn & pend_q;
  assign mem_re     = rstn & mem_re_q;
  assign mem_we     = rstn & mem_we_q;
  assign mem_addr   = rstn ? mem_addr_q : '0;
  assign mem_wdata  = rstn ? mem_wdata_q : '0;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache (default parameters: 64 lines, index = addr[7:2]).
module tb_dmem_cache;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic        read_enable;
  logic        flush;
  logic [31:0] data_out;
  logic        miss;
  logic        flush_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [2:0]  state_dbg;

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 1;
  logic [31:0] mem_value = '0;
  int          mem_busy_cnt = 0;
  int          we_hs = 0;
  bit          both_seen = 1'b0;
  int          busy_cycles = 0;
  logic [31:0] seen_addr = '0;
  logic [31:0] seen_wdata = '0;

  dmem_cache dut (
    .clk          (clk),
    .rstn         (rstn),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .flush        (flush),
    .data_out     (data_out),
    .miss         (miss),
    .flush_busy   (flush_busy),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Backing memory: answers mem_ready in the mem_lat-th cycle of a strobe.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_we && mem_ready) we_hs++;
      if (mem_re && mem_we) both_seen = 1'b1;
      #2;
      if (mem_re || mem_we) begin
        mem_busy_cnt++;
        mem_ready = (mem_busy_cnt == mem_lat);
        mem_rdata = (mem_busy_cnt == mem_lat) ? mem_value : 32'h0;
      end else begin
        mem_busy_cnt = 0;
        mem_ready    = 1'b0;
        mem_rdata    = 32'h0;
      end
    end
  end

  // Count cycles with flush_busy high
  always @(negedge clk) begin
    if (flush_busy === 1'b1) busy_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One requester access; returns stall cycles and data_out in the completing cycle.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int lat, input logic [31:0] rdata,
                        output int stall, output logic [31:0] dout);
    mem_lat      = lat;
    mem_value    = rdata;
    addr         = a;
    data_in      = wd;
    write_enable = wr;
    read_enable  = !wr;
    stall        = 0;
    dout         = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_re || mem_we) begin
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end
      if (miss !== 1'b1) begin
        dout = data_out;
        break;
      end
      stall++;
    end
    tick();
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  // Directed sequence
  initial begin
    int          stall;
    int          busy_n;
    int          we0;
    logic [31:0] dout;

    rstn = 1'b0; addr = '0; data_in = '0;
    write_enable = 1'b0; read_enable = 1'b0; flush = 1'b0;

    // Reset: outputs quiet even with a read request present
    repeat (3) tick();
    read_enable = 1'b1;
    addr        = 32'h100;
    @(negedge clk);
    chk("rst_miss", {31'b0, miss}, 32'h0);
    chk("rst_flush_busy", {31'b0, flush_busy}, 32'h0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    tick();
    rstn        = 1'b1;
    read_enable = 1'b0;
    @(negedge clk);
    chk("rst_state", {29'b0, state_dbg}, 32'h0);
    tick();

    // Cold read, memory answers in the 3rd FILL cycle
    access(1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, stall, dout);
    chk("cold_stall", stall, 4);
    chk("cold_data", dout, 32'hDEADBEEF);
    chk("cold_mem_addr", seen_addr, 32'h100);
    access(1'b0, 32'h100, 32'h0, 1, 32'h0, stall, dout);
    chk("reread_stall", stall, 0);
    chk("reread_data", dout, 32'hDEADBEEF);

    // Minimum miss latency on another line
    access(1'b0, 32'h104, 32'h0, 1, 32'hCAFE0001, stall, dout);
    chk("minlat_stall", stall, 2);
    chk("minlat_data", dout, 32'hCAFE0001);

    // Conflict on index 0
    access(1'b0, 32'h200, 32'h0, 1, 32'h22222222, stall, dout);
    chk("conflict_stall", stall, 2);
    chk("conflict_data", dout, 32'h22222222);
    access(1'b0, 32'h100, 32'h0, 1, 32'h11111111, stall, dout);
    chk("conflict_back_stall", stall, 2);
    chk("conflict_back_data", dout, 32'h11111111);

    // Write hit: one handshake, line updated
    we0 = we_hs;
    access(1'b1, 32'h100, 32'h12345678, 2, 32'h0, stall, dout);
    chk("wrhit_stall", stall, 3);
    chk("wrhit_handshakes", we_hs - we0, 1);
    chk("wrhit_mem_addr", seen_addr, 32'h100);
    chk("wrhit_mem_wdata", seen_wdata, 32'h12345678);
    chk("wrhit_done_data", dout, 32'h12345678);
    access(1'b0, 32'h100, 32'h0, 1, 32'h0, stall, dout);
    chk("wrhit_read_stall", stall, 0);
    chk("wrhit_read_data", dout, 32'h12345678);

    // Write miss: no allocate
    access(1'b1, 32'h200, 32'hABCD0000, 1, 32'h0, stall, dout);
    chk("wrmiss_stall", stall, 2);
    access(1'b0, 32'h200, 32'h0, 1, 32'h55555555, stall, dout);
    chk("wrmiss_read_stall", stall, 2);
    chk("wrmiss_read_data", dout, 32'h55555555);
    access(1'b0, 32'h104, 32'h0, 1, 32'h0, stall, dout);
    chk("line1_hit_stall", stall, 0);
    chk("line1_hit_data", dout, 32'hCAFE0001);

    // Flush with a read of a cached line pending
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_pulse_cycle", {31'b0, flush_busy}, 32'h0);
    tick();
    flush       = 1'b0;
    mem_lat     = 1;
    mem_value   = 32'h66666666;
    addr        = 32'h200;
    read_enable = 1'b1;
    busy_n = 0;
    stall  = 0;
    dout   = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (flush_busy === 1'b1) busy_n++;
      if (miss !== 1'b1) begin
        dout = data_out;
        break;
      end
      stall++;
    end
    tick();
    read_enable = 1'b0;
    chk("flush_busy_cycles", busy_n, 65);
    chk("flush_read_stall", stall, 67);
    chk("flush_read_data", dout, 32'h66666666);
    access(1'b0, 32'h104, 32'h0, 1, 32'hCAFE0002, stall, dout);
    chk("flush_line1_stall", stall, 2);

    // Flush restarted mid-sweep
    busy_cycles = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (flush_busy !== 1'b1) break;
    end
    chk("flush_restart_cycles", busy_cycles, 74);
    tick();

    // Reset in the middle of FILL
    mem_lat     = 10;
    mem_value   = 32'h99999999;
    addr        = 32'h300;
    read_enable = 1'b1;
    @(negedge clk);
    chk("rfill_miss", {31'b0, miss}, 32'h1);
    tick();
    @(negedge clk);
    chk("rfill_mem_re", {31'b0, mem_re}, 32'h1);
    chk("rfill_state", {29'b0, state_dbg}, 32'h1);
    chk("rfill_mem_addr", mem_addr, 32'h300);
    tick();
    rstn = 1'b0;
    @(negedge clk);
    chk("rfill_rst_mem_re", {31'b0, mem_re}, 32'h0);
    chk("rfill_rst_miss", {31'b0, miss}, 32'h0);
    tick();
    rstn        = 1'b1;
    read_enable = 1'b0;
    @(negedge clk);
    chk("rfill_after_mem_re", {31'b0, mem_re}, 32'h0);
    chk("rfill_after_state", {29'b0, state_dbg}, 32'h0);
    tick();
    access(1'b0, 32'h300, 32'h0, 1, 32'h77777777, stall, dout);
    chk("rfill_reread_stall", stall, 2);
    chk("rfill_reread_data", dout, 32'h77777777);

    chk("strobes_exclusive", {31'b0, both_seen}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
